// File: rtl/vga_pkg.sv
// Shared VGA timing types, the 640x480@60 preset and the region-sum helper.
package vga_pkg;

    localparam int unsigned MAX_PIX_LAT = 4;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register aligning timing decodes with the pixel source latency.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{pixel_clk, reset_n, enable};
        assign dout        = din;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge pixel_clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q <= '0;
            end else if (enable) begin
                stage_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, pipelined sync/blank decodes and blank-gated colour.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_640x480_60.h_active,
    parameter int unsigned H_FP      = VGA_640x480_60.h_fp,
    parameter int unsigned H_SYNC    = VGA_640x480_60.h_sync,
    parameter int unsigned H_BP      = VGA_640x480_60.h_bp,
    parameter int unsigned V_ACTIVE  = VGA_640x480_60.v_active,
    parameter int unsigned V_FP      = VGA_640x480_60.v_fp,
    parameter int unsigned V_SYNC    = VGA_640x480_60.v_sync,
    parameter int unsigned V_BP      = VGA_640x480_60.v_bp,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned PIX_LAT   = 1
) (
    input  logic                   pixel_clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic [COORD_W-1:0]     x_coord,
    output logic [COORD_W-1:0]     y_coord,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   drawn,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B
);

    localparam int unsigned H_TOT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Parameter sanity: every region present, latency in range, counters fit.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_region
        $error("vga_timing_gen: zero-width timing region");
    end
    if (PIX_LAT > MAX_PIX_LAT) begin : g_bad_lat
        $error("vga_timing_gen: PIX_LAT out of range 0..4");
    end
    if (longint'(H_TOT) > (longint'(1) << COORD_W) ||
        longint'(V_TOT) > (longint'(1) << COORD_W)) begin : g_bad_coord
        $error("vga_timing_gen: total exceeds coordinate range");
    end

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG    = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG    = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic               HS_ON     = 1'(HSYNC_POL);
    localparam logic               VS_ON     = 1'(VSYNC_POL);

    logic [COORD_W-1:0] h_q;
    logic [COORD_W-1:0] v_q;
    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;

    // Raster advance: h wraps every line, v steps on the h wrap.
    always_comb begin
        h_nxt = h_q + COORD_W'(1);
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (enable) begin
            h_q <= h_nxt;
            v_q <= v_nxt;
        end
    end

    assign x_coord     = h_q;
    assign y_coord     = v_q;
    assign line_start  = (h_q == '0);
    assign frame_start = (h_q == '0) && (v_q == '0);

    logic act_raw;
    logic hs_raw;
    logic vs_raw;
    logic act_dly;
    logic hs_dly;
    logic vs_dly;

    assign act_raw = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign hs_raw  = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_raw  = (v_q >= VS_BEG) && (v_q < VS_END);

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .din       ({act_raw, hs_raw, vs_raw}),
        .dout      ({act_dly, hs_dly, vs_dly})
    );

    // Final output stage; colour is blanked outside the active window.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            drawn <= 1'b0;
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            R     <= '0;
            G     <= '0;
            B     <= '0;
        end else if (enable) begin
            drawn <= act_dly;
            hsync <= ~(hs_dly ^ HS_ON);
            vsync <= ~(vs_dly ^ VS_ON);
            if (act_dly) begin
                R <= rgb_in[3*COLOR_W-1:2*COLOR_W];
                G <= rgb_in[2*COLOR_W-1:COLOR_W];
                B <= rgb_in[COLOR_W-1:0];
            end else begin
                R <= '0;
                G <= '0;
                B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, PIX_LAT=2 and reduced positive-polarity instances.
module tb_vga_timing_gen;

    localparam int DEF_HA = 640, DEF_HFP = 16, DEF_HSY = 96, DEF_HT = 800;
    localparam int DEF_VA = 480, DEF_VFP = 10, DEF_VSY = 2,  DEF_VT = 525;
    localparam int SM_HA  = 8,   SM_HFP  = 2,  SM_HSY  = 3,  SM_HT  = 15;
    localparam int SM_VA  = 4,   SM_VFP  = 1,  SM_VSY  = 1,  SM_VT  = 7;

    logic pixel_clk = 1'b0;
    logic reset_n;
    logic enable;
    logic [11:0] rgb_def, rgb_lat, rgb_sm;

    logic [9:0] x_def, y_def, x_lat, y_lat;
    logic [3:0] x_sm, y_sm;
    logic ls_def, fs_def, hs_def, vs_def, dr_def;
    logic ls_lat, fs_lat, hs_lat, vs_lat, dr_lat;
    logic ls_sm, fs_sm, hs_sm, vs_sm, dr_sm;
    logic [3:0] r_def, g_def, b_def, r_lat, g_lat, b_lat, r_sm, g_sm, b_sm;

    int checks = 0;
    int failures = 0;
    int t = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen u_def (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable), .rgb_in(rgb_def),
        .x_coord(x_def), .y_coord(y_def), .line_start(ls_def), .frame_start(fs_def),
        .hsync(hs_def), .vsync(vs_def), .drawn(dr_def), .R(r_def), .G(g_def), .B(b_def)
    );

    vga_timing_gen #(.PIX_LAT(2)) u_lat (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable), .rgb_in(rgb_lat),
        .x_coord(x_lat), .y_coord(y_lat), .line_start(ls_lat), .frame_start(fs_lat),
        .hsync(hs_lat), .vsync(vs_lat), .drawn(dr_lat), .R(r_lat), .G(g_lat), .B(b_lat)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .COORD_W(4), .PIX_LAT(1)
    ) u_sm (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable), .rgb_in(rgb_sm),
        .x_coord(x_sm), .y_coord(y_sm), .line_start(ls_sm), .frame_start(fs_sm),
        .hsync(hs_sm), .vsync(vs_sm), .drawn(dr_sm), .R(r_sm), .G(g_sm), .B(b_sm)
    );

    // Raster model: position k ticks after reset; negative k means pipeline still empty.
    function automatic logic m_win(input int c, input int lo, input int len);
        return (c >= lo) && (c < lo + len);
    endfunction

    function automatic logic m_act(input int k, input int ha, input int ht, input int va, input int vt);
        if (k < 0) return 1'b0;
        return ((k % ht) < ha) && (((k / ht) % vt) < va);
    endfunction

    function automatic logic m_hs(input int k, input int lo, input int len, input int ht);
        if (k < 0) return 1'b0;
        return m_win(k % ht, lo, len);
    endfunction

    function automatic logic m_vs(input int k, input int lo, input int len, input int ht, input int vt);
        if (k < 0) return 1'b0;
        return m_win((k / ht) % vt, lo, len);
    endfunction

    function automatic logic [3:0] m_pix(input int k, input int ht);
        if (k < 0) return 4'd0;
        return 4'((k % ht) & 15);
    endfunction

    // Pixel source presents the colour of the position PIX_LAT ticks back.
    task automatic step(input logic en);
        enable  = en;
        rgb_def = {3{m_pix(t - 1, DEF_HT)}};
        rgb_lat = {3{m_pix(t - 2, DEF_HT)}};
        rgb_sm  = {3{m_pix(t - 1, SM_HT)}};
        @(posedge pixel_clk);
        if (en) t++;
        @(negedge pixel_clk);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        t       = 0;
        repeat (2) @(negedge pixel_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [36:0] got;
        reset_n = 1'b0;
        enable  = 1'b1;
        rgb_def = 12'hFFF;
        repeat (3) @(negedge pixel_clk);
        got = {x_def, y_def, ls_def, fs_def, hs_def, vs_def, dr_def, r_def, g_def, b_def};
        checks++;
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0}) begin
            failures++;
            $display("FAIL reset_def: got %h want %h", got, {10'd0, 10'd0, 5'b11110, 12'd0});
        end
        checks++;
        if ({hs_sm, vs_sm, dr_sm, x_sm, y_sm} !== 11'd0) begin
            failures++;
            $display("FAIL reset_sm: got hs=%b vs=%b dr=%b x=%0d y=%0d want all 0", hs_sm, vs_sm, dr_sm, x_sm, y_sm);
        end
        checks++;
        if ({dr_lat, r_lat, x_lat} !== 15'd0) begin
            failures++;
            $display("FAIL reset_lat: got dr=%b r=%0d x=%0d want 0", dr_lat, r_lat, x_lat);
        end
        reset_n = 1'b1;
        enable  = 1'b0;
    endtask

    task automatic test_default_timing();
        logic [36:0] got, exp;
        int p, hs_low, hs_first_x, vs_low;
        logic a;
        hs_low = 0; hs_first_x = -1; vs_low = 0;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            step(1'b1);
            p = t - 2;
            a = m_act(p, DEF_HA, DEF_HT, DEF_VA, DEF_VT);
            exp = {10'(t % DEF_HT), 10'((t / DEF_HT) % DEF_VT), (t % DEF_HT) == 0,
                   (t % (DEF_HT * DEF_VT)) == 0,
                   ~m_hs(p, DEF_HA + DEF_HFP, DEF_HSY, DEF_HT),
                   ~m_vs(p, DEF_VA + DEF_VFP, DEF_VSY, DEF_HT, DEF_VT),
                   a, a ? {3{m_pix(p, DEF_HT)}} : 12'd0};
            got = {x_def, y_def, ls_def, fs_def, hs_def, vs_def, dr_def, r_def, g_def, b_def};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL def_tick t=%0d: got %h want %h", t, got, exp);
            end
            if (hs_def === 1'b0 && hs_first_x < 0) hs_first_x = int'(x_def);
            if (t >= 800 && t < 1600 && hs_def === 1'b0) hs_low++;
            if (vs_def !== 1'b1) vs_low++;
        end
        checks++;
        if (hs_first_x != 658) begin
            failures++;
            $display("FAIL def_hsync_start: got x=%0d want 658", hs_first_x);
        end
        checks++;
        if (hs_low != 96) begin
            failures++;
            $display("FAIL def_hsync_width: got %0d want 96", hs_low);
        end
        checks++;
        if (vs_low != 0) begin
            failures++;
            $display("FAIL def_vsync_idle: got %0d low ticks want 0", vs_low);
        end
    endtask

    task automatic test_latency();
        int p, blank_bad;
        logic a;
        logic [12:0] exp;
        blank_bad = 0;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            step(1'b1);
            p = t - 3;
            a = m_act(p, DEF_HA, DEF_HT, DEF_VA, DEF_VT);
            exp = {a, a ? {3{m_pix(p, DEF_HT)}} : 12'd0};
            checks++;
            if ({dr_lat, r_lat, g_lat, b_lat} !== exp) begin
                failures++;
                $display("FAIL lat_tick t=%0d: got dr=%b rgb=%h want %h", t, dr_lat, {r_lat, g_lat, b_lat}, exp);
            end
            if (p >= 0 && (p % DEF_HT) >= DEF_HA && r_lat !== 4'd0) blank_bad++;
            if (t == 3) begin
                checks++;
                if ({dr_lat, r_lat} !== 5'b1_0000) begin
                    failures++;
                    $display("FAIL lat_first_pixel: got dr=%b R=%0d want dr=1 R=0", dr_lat, r_lat);
                end
            end
            if (t == 8) begin
                checks++;
                if (r_lat !== 4'd5) begin
                    failures++;
                    $display("FAIL lat_pixel5: got R=%0d want 5", r_lat);
                end
            end
        end
        checks++;
        if (blank_bad != 0) begin
            failures++;
            $display("FAIL lat_blanking: got %0d nonzero R in blanking want 0", blank_bad);
        end
    endtask

    task automatic test_polarity();
        int p, hs_hi_line, hs_hi_frame, vs_hi_frame, fs_first, fs_second;
        logic a;
        logic [16:0] exp;
        hs_hi_line = 0; hs_hi_frame = 0; vs_hi_frame = 0; fs_first = -1; fs_second = -1;
        do_reset();
        for (int i = 0; i < 230; i++) begin
            step(1'b1);
            p = t - 2;
            a = m_act(p, SM_HA, SM_HT, SM_VA, SM_VT);
            exp = {4'(t % SM_HT), 4'((t / SM_HT) % SM_VT),
                   m_hs(p, SM_HA + SM_HFP, SM_HSY, SM_HT),
                   m_vs(p, SM_VA + SM_VFP, SM_VSY, SM_HT, SM_VT),
                   a, a ? m_pix(p, SM_HT) : 4'd0, (t % (SM_HT * SM_VT)) == 0, (t % SM_HT) == 0};
            checks++;
            if ({x_sm, y_sm, hs_sm, vs_sm, dr_sm, r_sm, fs_sm, ls_sm} !== exp) begin
                failures++;
                $display("FAIL sm_tick t=%0d: got %h want %h", t,
                         {x_sm, y_sm, hs_sm, vs_sm, dr_sm, r_sm, fs_sm, ls_sm}, exp);
            end
            if (t >= 20 && t < 35 && hs_sm === 1'b1) hs_hi_line++;
            if (t >= 20 && t < 125 && hs_sm === 1'b1) hs_hi_frame++;
            if (t >= 20 && t < 125 && vs_sm === 1'b1) vs_hi_frame++;
            if (fs_sm === 1'b1) begin
                if (fs_first < 0) fs_first = t;
                else if (fs_second < 0) fs_second = t;
            end
        end
        checks++;
        if (hs_hi_line != 3) begin
            failures++;
            $display("FAIL pol_hsync_line: got %0d high ticks want 3", hs_hi_line);
        end
        checks++;
        if (hs_hi_frame != 21 || vs_hi_frame != 15) begin
            failures++;
            $display("FAIL pol_frame: got hs=%0d vs=%0d want hs=21 vs=15", hs_hi_frame, vs_hi_frame);
        end
        checks++;
        if (fs_first < 0 || fs_second - fs_first != 105) begin
            failures++;
            $display("FAIL pol_frame_period: got %0d want 105", fs_second - fs_first);
        end
    endtask

    task automatic test_enable_gating();
        int p, rise1, rise2;
        logic prev_fs, a;
        logic [13:0] exp;
        rise1 = -1; rise2 = -1; prev_fs = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 460; cyc++) begin
            step(cyc % 2 == 0);
            p = t - 2;
            a = m_act(p, SM_HA, SM_HT, SM_VA, SM_VT);
            exp = {4'(t % SM_HT), 4'((t / SM_HT) % SM_VT),
                   m_hs(p, SM_HA + SM_HFP, SM_HSY, SM_HT),
                   m_vs(p, SM_VA + SM_VFP, SM_VSY, SM_HT, SM_VT),
                   a, a ? 3'(m_pix(p, SM_HT)) : 3'd0};
            checks++;
            if ({x_sm, y_sm, hs_sm, vs_sm, dr_sm, b_sm[2:0]} !== exp) begin
                failures++;
                $display("FAIL gate_tick cyc=%0d t=%0d: got %h want %h", cyc, t,
                         {x_sm, y_sm, hs_sm, vs_sm, dr_sm, b_sm[2:0]}, exp);
            end
            if (fs_sm === 1'b1 && prev_fs === 1'b0) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            prev_fs = fs_sm;
        end
        checks++;
        if (rise1 < 0 || rise2 - rise1 != 210) begin
            failures++;
            $display("FAIL gate_frame_period: got %0d cycles want 210", rise2 - rise1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (104) step(1'b1);
        checks++;
        if ({x_sm, y_sm, fs_sm} !== {4'd14, 4'd6, 1'b0}) begin
            failures++;
            $display("FAIL wrap_before: got x=%0d y=%0d fs=%b want 14 6 0", x_sm, y_sm, fs_sm);
        end
        step(1'b1);
        checks++;
        if ({x_sm, y_sm, fs_sm, ls_sm} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL wrap_after: got x=%0d y=%0d fs=%b ls=%b want 0 0 1 1", x_sm, y_sm, fs_sm, ls_sm);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        repeat (700) step(1'b1);
        checks++;
        if (hs_def !== 1'b0 || x_def !== 10'd700) begin
            failures++;
            $display("FAIL mid_pre: got hs=%b x=%0d want 0 700", hs_def, x_def);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({x_def, y_def, hs_def, vs_def, dr_def, r_def, g_def, b_def} !== {20'd0, 3'b110, 12'd0}) begin
            failures++;
            $display("FAIL mid_async: got x=%0d y=%0d hs=%b vs=%b dr=%b rgb=%h want 0 0 1 1 0 0",
                     x_def, y_def, hs_def, vs_def, dr_def, {r_def, g_def, b_def});
        end
        checks++;
        if ({hs_sm, vs_sm} !== 2'b00) begin
            failures++;
            $display("FAIL mid_async_sm: got hs=%b vs=%b want 0 0", hs_sm, vs_sm);
        end
        @(negedge pixel_clk);
        reset_n = 1'b1;
        t = 0;
        checks++;
        if ({fs_def, ls_def} !== 2'b11) begin
            failures++;
            $display("FAIL mid_release_fs: got fs=%b ls=%b want 1 1", fs_def, ls_def);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            checks++;
            if ({hs_def, x_def} !== {1'b1, 10'(t)}) begin
                failures++;
                $display("FAIL mid_resume t=%0d: got hs=%b x=%0d want 1 %0d", t, hs_def, x_def, t);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        rgb_def = '0;
        rgb_lat = '0;
        rgb_sm  = '0;
        test_reset();
        test_default_timing();
        test_latency();
        test_polarity();
        test_enable_gating();
        test_wrap();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: horizontal active, front porch, sync and back porch widths in pixels.
REQ-002 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: the same four regions in lines.
REQ-003 SHALL have parameters HSYNC_POL=0 and VSYNC_POL=0: asserted sync level, where 0 is active-low.
REQ-004 SHALL have parameters COLOR_W=4 (bits per colour channel), COORD_W=10 (coordinate width) and PIX_LAT=1 (pixel-source latency in ticks, legal range 0..4).
REQ-005 SHALL have port pixel_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: pixel tick; all state advances only on cycles where it is 1.
REQ-008 SHALL have port rgb_in, input, 3*COLOR_W bits: pixel colour packed {R,G,B}, valid PIX_LAT ticks after its coordinate.
REQ-009 SHALL have ports x_coord and y_coord, outputs, COORD_W bits each: current counter position.
REQ-010 SHALL have ports line_start and frame_start, outputs, 1 bit each: position decodes.
REQ-011 SHALL have ports hsync, vsync and drawn, outputs, 1 bit each: pipelined timing signals.
REQ-012 SHALL have ports R, G and B, outputs, COLOR_W bits each: blank-gated colour.

Function
REQ-013 SHALL hold horizontal counter h in 0..H_TOT-1, where H_TOT = sum of the H parameters; 800 at default values.
REQ-014 SHALL hold vertical counter v in 0..V_TOT-1, where V_TOT = sum of the V parameters; 525 at default values.
REQ-015 SHALL increment h on each enable tick, wrapping H_TOT-1 -> 0.
REQ-016 SHALL increment v only on the tick where h wraps, wrapping V_TOT-1 -> 0 on the tick where h and v wrap together.
REQ-017 SHALL order the regions active, front porch, sync, back porch on both axes.
REQ-018 SHALL drive x_coord = h and y_coord = v directly from the counter registers, with no added latency.
REQ-019 SHALL assert line_start when h==0 and frame_start when h==0 and v==0, both combinational decodes of the registers.
REQ-020 SHALL define raw decodes:
  - act = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
REQ-021 SHALL delay act, hs and vs through a PIX_LAT-deep shift register that advances only on enable ticks.
REQ-022 SHALL, on each enable tick, register the outputs:
  - drawn <= delayed act
  - hsync <= delayed hs XNOR HSYNC_POL
  - vsync <= delayed vs XNOR VSYNC_POL
  - {R,G,B} <= delayed act ? rgb_in : 0
REQ-023 SHALL therefore have total latency PIX_LAT+1 enable ticks from counter state to the hsync/vsync/drawn/R/G/B outputs.
REQ-024 SHALL, when enable is 0, hold the counters, the pipeline and all registered outputs unchanged.
REQ-025 SHALL force R, G and B to 0 whenever the aligned drawn is 0, regardless of rgb_in.
REQ-026 SHALL reject at elaboration: any zero-width region, PIX_LAT>4, or H_TOT or V_TOT greater than 2**COORD_W.

Reset
REQ-027 SHALL, while reset_n is low (asynchronous):
  - set h and v to 0
  - clear all pipeline stages to act=0, hs=0, vs=0
  - set drawn=0 and R=G=B=0
  - set hsync=!HSYNC_POL and vsync=!VSYNC_POL
REQ-028 SHALL resume on release with the first enable tick advancing h from 0; a reset mid-frame discards the in-flight pipeline with no partial sync pulse.

Structure
REQ-029 SHALL place in package vga_pkg:
  - typedef vga_timing_t (struct of the eight region widths)
  - constant VGA_640x480_60 with the default values
  - function vga_total() returning the summed region width
REQ-030 SHALL implement the PIX_LAT delay as sub-module vga_delay_line (parameters WIDTH, DEPTH; DEPTH=0 is a wire), instantiated once for {act,hs,vs}.

Verification
REQ-031 SHALL verify defaults with enable=1 for one frame -> exactly 420000 ticks between frame_start pulses; hsync low for 96 ticks per line starting at h=656+PIX_LAT+1; vsync low for lines 490-491 only.
REQ-032 SHALL verify latency with PIX_LAT=2 and rgb_in=x_coord[3:0] replicated -> R at the first active pixel equals 0 three ticks after frame_start; R=0 at every h>=640 position.
REQ-033 SHALL verify enable gating with enable toggling 1,0 -> frame period 840000 cycles; outputs identical to the enable=1 run when sampled on enable ticks.
REQ-034 SHALL verify reset mid-frame by asserting reset_n=0 at h=700, v=300 -> immediately hsync=1, vsync=1, drawn=0, RGB=0, x=y=0; after release, the first frame_start occurs on the first tick.
REQ-035 SHALL verify polarity with HSYNC_POL=1, VSYNC_POL=1 and reduced timing 8/2/3/2 x 4/1/1/1 -> hsync high for exactly 3 ticks per 15-tick line; vsync high for 1 line per 7-line frame.
REQ-036 SHALL verify wrap with h=H_TOT-1 and v=V_TOT-1 -> the next tick gives x=0, y=0 and frame_start=1.
